// File: rtl/soc_system_key_pio.sv
// -----------------------------------------------------------------------------
// soc_system_key_pio
// Avalon-MM input PIO for push-buttons: sync, debounce, edge capture, masked irq.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module soc_system_key_pio #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 1,
  parameter logic [3:0]  RESET_LEVEL     = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [3:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [19:0] c_CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_stable;
  logic [3:0] r_irqmask;
  logic [3:0] r_edgecap;

  logic [3:0] w_upd;
  logic [3:0] w_cap;
  logic [3:0] w_clr;
  logic       w_wr;
  logic       w_wr_mask;
  logic       w_wr_edge;
  logic       w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr & (address == 2'd1);
  assign w_wr_edge = w_wr & (address == 2'd3);
  assign w_clr     = w_wr_edge ? writedata[3:0] : 4'h0;
  assign w_unused_wdata = ^writedata[31:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic [19:0] r_cnt;

      assign w_upd[gi] = (r_sync2[gi] != r_stable[gi]) && (r_cnt == c_CNT_MAX);

      // Counter only runs while the synchronised bit disagrees with the stable value
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= 20'd0;
        end else if (r_sync2[gi] == r_stable[gi] || w_upd[gi]) begin
          r_cnt <= 20'd0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_cap = 4'h0;
    case (EDGE_TYPE)
      0:       w_cap = w_upd & r_sync2;
      1:       w_cap = w_upd & ~r_sync2;
      default: w_cap = w_upd;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable  <= RESET_LEVEL;
      r_irqmask <= 4'h0;
      r_edgecap <= 4'h0;
    end else begin
      r_stable <= (r_stable & ~w_upd) | (r_sync2 & w_upd);
      if (w_wr_mask) begin
        r_irqmask <= writedata[3:0];
      end
      // A new capture overrides a simultaneous write-one-to-clear
      r_edgecap <= (r_edgecap & ~w_clr) | w_cap;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0:    readdata = {28'h0, r_stable};
      2'd1:    readdata = {28'h0, r_irqmask};
      2'd3:    readdata = {28'h0, r_edgecap};
      default: readdata = 32'h0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

`default_nettype wire

// File: tb/tb_soc_system_key_pio.sv
// -----------------------------------------------------------------------------
// tb_soc_system_key_pio
// Directed stimulus with a queue-based scoreboard and negedge monitor.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_soc_system_key_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  typedef struct {
    logic [31:0] exp;
    bit          is_irq;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  bit   tb_sample;
  int   n_checks;
  int   n_fail;

  soc_system_key_pio #(
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1),
    .RESET_LEVEL     (4'hF)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation whenever the stimulus side flags a sample
  always @(negedge clk) begin
    if (tb_sample) begin
      exp_t        e;
      logic [31:0] act;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got sample with no expectation");
      end else begin
        e   = sb_q.pop_front();
        act = e.is_irq ? {31'h0, irq} : readdata;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    address  = a;
    e.exp    = v;
    e.is_irq = 1'b0;
    e.name   = nm;
    sb_q.push_back(e);
    tb_sample = 1'b1;
    @(negedge clk);
    #1;
    tb_sample = 1'b0;
  endtask

  task automatic expect_irq(input logic v, input string nm);
    exp_t e;
    e.exp    = {31'h0, v};
    e.is_irq = 1'b1;
    e.name   = nm;
    sb_q.push_back(e);
    tb_sample = 1'b1;
    @(negedge clk);
    #1;
    tb_sample = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    tb_sample  = 1'b0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;

    // Reset state
    edges(3);
    reset_n = 1'b1;
    edges(2);
    expect_rd(2'd0, 32'hF, "rst_data");
    expect_rd(2'd1, 32'h0, "rst_mask");
    expect_rd(2'd2, 32'h0, "rst_addr2");
    expect_rd(2'd3, 32'h0, "rst_edgecap");
    expect_irq(1'b0, "rst_irq");

    // Single falling edge on bit 0: stable updates 6 edges after the drive edge
    bus_write(2'd1, 32'h1);
    in_port = 4'hE;
    edges(5);
    expect_rd(2'd0, 32'hF, "k0_before_deb");
    edges(1);
    expect_rd(2'd0, 32'hE, "k0_data");
    expect_rd(2'd3, 32'h1, "k0_edgecap");
    expect_irq(1'b1, "k0_irq");
    bus_write(2'd3, 32'h1);
    expect_rd(2'd3, 32'h0, "k0_w1c");
    expect_irq(1'b0, "k0_irq_clr");

    // Release: rising edge must not capture
    in_port = 4'hF;
    edges(10);
    expect_rd(2'd0, 32'hF, "k0_rel_data");
    expect_rd(2'd3, 32'h0, "k0_rel_nocap");

    // Three-cycle glitch on bit 1 is filtered
    in_port = 4'hD;
    edges(3);
    in_port = 4'hF;
    edges(10);
    expect_rd(2'd0, 32'hF, "glitch_data");
    expect_rd(2'd3, 32'h0, "glitch_edgecap");
    expect_irq(1'b0, "glitch_irq");

    // Bit 2 with mask off: only falling edges capture
    bus_write(2'd1, 32'h0);
    in_port = 4'hB;
    edges(10);
    expect_rd(2'd3, 32'h4, "k2_press1");
    bus_write(2'd3, 32'h4);
    in_port = 4'hF;
    edges(10);
    expect_rd(2'd3, 32'h0, "k2_release_nocap");
    in_port = 4'hB;
    edges(10);
    expect_rd(2'd3, 32'h4, "k2_press2");
    expect_irq(1'b0, "k2_masked_irq");
    bus_write(2'd1, 32'h4);
    expect_irq(1'b1, "k2_unmask_irq");
    in_port = 4'hF;
    edges(10);
    bus_write(2'd3, 32'h4);
    expect_rd(2'd3, 32'h0, "k2_cleared");

    // Set-wins: W1C of bit 3 on the capture edge, bit 0 clears normally
    in_port = 4'hE;
    edges(10);
    expect_rd(2'd3, 32'h1, "sw_bit0_set");
    in_port = 4'h6;
    edges(5);
    bus_write(2'd3, 32'h9);
    expect_rd(2'd3, 32'h8, "sw_edgecap");
    expect_rd(2'd0, 32'h6, "sw_data");
    expect_irq(1'b0, "sw_irq_masked");

    // Async reset mid-debounce with captured bits and all bits masked in
    in_port = 4'hF;
    edges(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'hC;
    edges(10);
    expect_rd(2'd3, 32'h3, "ar_edgecap_pre");
    bus_write(2'd1, 32'hF);
    expect_irq(1'b1, "ar_irq_pre");
    in_port = 4'hF;
    edges(4);
    reset_n = 1'b0;
    expect_irq(1'b0, "ar_irq_async");
    expect_rd(2'd0, 32'hF, "ar_data_rst");
    expect_rd(2'd1, 32'h0, "ar_mask_rst");
    expect_rd(2'd3, 32'h0, "ar_edgecap_rst");
    reset_n = 1'b1;
    edges(10);
    expect_rd(2'd0, 32'hF, "ar_data_post");
    expect_rd(2'd3, 32'h0, "ar_no_spurious");
    expect_irq(1'b0, "ar_irq_post");

    edges(2);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/soc_system_key_pio.md
# soc_system_key_pio

Avalon-MM slave input PIO for the board push-buttons: the input-side counterpart of the LED output PIO on the same HPS lightweight bridge. Samples a 4-bit asynchronous key bus, synchronises and debounces each bit, and latches qualifying edges into a per-bit edge-capture register. Raises a level-sensitive interrupt to the HPS through a per-bit mask. Register reads are zero-wait-state (read latency 0), with the same bus timing as the other PIOs in the system.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised bit must differ from its stable value before the stable value updates (1 ms at 50 MHz). Legal range 1 to 2^20.
- EDGE_TYPE, 1: edges latched into capture. 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, 4'hF: reset value of the synchroniser and stable registers. Keys idle high.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select (word address)
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  4  raw key inputs, asynchronous to clk
- readdata  out  32  combinational read data; bits [31:4] are always 0
- irq  out  1  interrupt, level, active-high

## Operation
Register map:
- Address 0, DATA, read-only: the debounced stable value. Writes are ignored.
- Address 1, IRQMASK, read/write: bits [3:0]. Reset value 0.
- Address 2: reads 0. Writes are ignored.
- Address 3, EDGECAP: bits [3:0]. Writing 1 to a bit clears that bit; writing 0 leaves it unchanged.

Bus behaviour:
- A write occurs when chipselect=1, write_n=0, and address selects the register.
- readdata is a combinational mux on address. It does not depend on chipselect.

Per-bit datapath:
- Two-flop synchroniser: sync1 then sync2.
- 20-bit debounce counter, per bit.
  - If sync2 == stable, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync2 != stable, stable takes the value of sync2 on that edge and the counter clears.
- A capture event occurs on the same edge that stable updates, when the transition matches EDGE_TYPE. Falling means 1 to 0; rising means 0 to 1.
- irq = |(EDGECAP & IRQMASK), combinational from registers.

Boundary rules:
- Pulse or glitch on sync2 shorter than DEBOUNCE_CYCLES: the counter clears on return, stable is unchanged, nothing is captured.
- Capture event and W1C clear of the same bit on the same edge: set wins, and the bit stays 1.
- Bits of a W1C write that are not being set clear normally.
- Capture of a bit that is already set: it stays 1. There is no count and no overflow flag.
- Changing IRQMASK affects irq immediately, on the cycle after the write edge. Captured bits are retained regardless of the mask.
- Reset asserted mid-operation, all registers return immediately (asynchronously) to:
  - sync1, sync2, stable: RESET_LEVEL
  - counters: 0
  - IRQMASK, EDGECAP: 0
  - irq: 0
- The release of reset_n is assumed synchronised externally. No capture may arise from reset values alone.

## Timing
- Raw change sampled by sync1 at edge k: sync2 updates at k+1, stable and EDGECAP update at k+DEBOUNCE_CYCLES+1.
- irq rises in the same cycle EDGECAP updates, if masked in.
- For DEBOUNCE_CYCLES=1: stable follows sync2 one edge later, so total latency is 2 edges from sync1.
- Register write takes effect at the clock edge where the write condition holds.
- readdata reflects the new value in the following cycle, with zero wait states.
- irq falls in the cycle after the W1C edge, unless set-wins applies.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and EDGE_TYPE=1.

- Reset with in_port=4'hF, then read address 0 → 0x0000000F. Read addresses 1, 2, 3 → 0. irq=0.
- Write IRQMASK=0x1, then drive in_port[0]=0 and hold. At k+5 (k = the sync1 sample edge): DATA reads 0xE, EDGECAP reads 0x1, irq=1. Write 0x1 to address 3 → EDGECAP=0 and irq=0 the next cycle.
- Drive in_port[1] low for 3 cycles, then high → DATA stays 0xF, EDGECAP stays 0, irq stays 0.
- Hold in_port[2] low, release it high, then press again. Only the falling edges set EDGECAP[2]. With IRQMASK=0, irq stays 0 while EDGECAP reads 0x4. Write IRQMASK=0x4 → irq=1 on the next cycle.
- Arrange the W1C write to address 3 with writedata=0x8 to land on the same edge as the in_port[3] falling capture → EDGECAP[3] reads 1 afterwards. In the same write, an already-set bit 0 in writedata=0x9 clears.
- Assert reset_n mid-debounce (counter=2) with EDGECAP=0x3 and IRQMASK=0xF → irq drops to 0 asynchronously and all registers read their reset values. With in_port still 4'hF after release, no spurious capture occurs.
